// File: rtl/fpu_rr_arbiter.sv
// Round-robin arbiter sharing one FPU slave port among N_MASTERS requesters over req/ack.
// Optional stall watchdog compiled in with FPU_ARB_TIMEOUT_EN.
module fpu_rr_arbiter #(
    parameter int N_MASTERS   = 4,
    parameter int SEL_W       = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [N_MASTERS-1:0] M_req,
    output logic [N_MASTERS-1:0] M_ack,
    output logic                 S_req,
    input  logic                 S_ack,
    output logic [SEL_W-1:0]     Select,
    output logic                 Busy,
    output logic                 Timeout_err,
    output logic [SEL_W-1:0]     Err_id
);

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_DONE  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [SEL_W-1:0] grant_r;
    logic [SEL_W-1:0] ptr_r;
    logic [SEL_W-1:0] winner_s;
    logic [SEL_W-1:0] idx_s;
    logic [SEL_W-1:0] ptr_nxt_s;
    logic             found_s;
    logic             abort_s;
    logic             ack_s;
    logic             expire_s;

    // Rotating search: first requester at or above ptr, wrapping to 0
    always_comb begin
        winner_s = ptr_r;
        found_s  = 1'b0;
        idx_s    = ptr_r;
        for (int i = 0; i < N_MASTERS; i++) begin
            idx_s = SEL_W'((int'(ptr_r) + i) % N_MASTERS);
            if (!found_s && M_req[idx_s]) begin
                winner_s = idx_s;
                found_s  = 1'b1;
            end else begin
                winner_s = winner_s;
            end
        end
    end

    assign ptr_nxt_s = (grant_r == SEL_W'(N_MASTERS - 1)) ? {SEL_W{1'b0}} : grant_r + SEL_W'(1);
    // Exit causes in priority order: withdrawal, then slave ack, then watchdog
    assign abort_s   = (state_r == ARB_GRANT) && !M_req[grant_r];
    assign ack_s     = (state_r == ARB_GRANT) && M_req[grant_r] && S_ack;

`ifdef FPU_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
    logic [CNT_W-1:0] cnt_r;
    logic [SEL_W-1:0] err_id_r;

    assign expire_s = (state_r == ARB_GRANT) && M_req[grant_r] && !S_ack &&
                      (cnt_r == CNT_W'(TIMEOUT_CYC - 1));

    // Watchdog counts GRANT cycles since entry; Err_id latches the hung master
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_r    <= '0;
            err_id_r <= '0;
        end else begin
            if (state_r == ARB_IDLE && found_s) begin
                cnt_r <= '0;
            end else if (state_r == ARB_GRANT) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
            if (expire_s) begin
                err_id_r <= grant_r;
            end else begin
                err_id_r <= err_id_r;
            end
        end
    end

    assign Err_id = err_id_r;
`else
    localparam int TMO_UNUSED = TIMEOUT_CYC;
    assign expire_s = 1'b0;
    assign Err_id   = '0;
`endif

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ARB_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Grant and priority pointer; ptr moves past the grantee on every exit
    always_ff @(posedge CLK) begin
        if (RST) begin
            grant_r <= '0;
            ptr_r   <= '0;
        end else begin
            if (state_r == ARB_IDLE && found_s) begin
                grant_r <= winner_s;
            end else begin
                grant_r <= grant_r;
            end
            if (state_r == ARB_DONE) begin
                ptr_r <= ptr_nxt_s;
            end else begin
                ptr_r <= ptr_r;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ARB_IDLE: begin
                if (found_s) begin
                    state_nxt_s = ARB_GRANT;
                end else begin
                    state_nxt_s = ARB_IDLE;
                end
            end
            ARB_GRANT: begin
                if (abort_s || ack_s || expire_s) begin
                    state_nxt_s = ARB_DONE;
                end else begin
                    state_nxt_s = ARB_GRANT;
                end
            end
            ARB_DONE: state_nxt_s = ARB_IDLE;
            default:  state_nxt_s = ARB_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        M_ack       = '0;
        S_req       = 1'b0;
        Select      = grant_r;
        Busy        = (state_r != ARB_IDLE);
        Timeout_err = expire_s;
        case (state_r)
            ARB_GRANT: begin
                S_req = !(abort_s || ack_s || expire_s);
                if (ack_s) begin
                    M_ack[grant_r] = 1'b1;
                end else begin
                    M_ack = '0;
                end
            end
            ARB_IDLE: S_req = 1'b0;
            ARB_DONE: S_req = 1'b0;
            default:  S_req = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_fpu_rr_arbiter.sv
// Self-checking bench for fpu_rr_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model of the arbitration rules.
module tb_fpu_rr_arbiter;

    localparam int N   = 4;
    localparam int TMO = 8;
`ifdef FPU_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] M_req;
    logic [3:0] M_ack;
    logic       S_req;
    logic       S_ack;
    logic [1:0] Select;
    logic       Busy;
    logic       Timeout_err;
    logic [1:0] Err_id;

    always #5 CLK = ~CLK;

    fpu_rr_arbiter #(.N_MASTERS(N), .SEL_W(2), .TIMEOUT_CYC(TMO)) dut (
        .CLK(CLK), .RST(RST), .M_req(M_req), .M_ack(M_ack), .S_req(S_req),
        .S_ack(S_ack), .Select(Select), .Busy(Busy), .Timeout_err(Timeout_err),
        .Err_id(Err_id)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: who owns the slave, whether that transaction has ended,
    // which master has top priority, and how long the owner has been waiting.
    int   m_owner = -1;
    bit   m_done  = 1'b0;
    int   m_prio  = 0;
    int   m_last  = 0;
    int   m_err   = 0;
    int   m_cnt   = 0;
    bit   m_exit;
    logic       e_sreq, e_busy, e_terr;
    logic [3:0] e_mack;
    logic [10:0] exp_v, obs_v;

    // Apply inputs mid-cycle and derive the expected outputs for this cycle
    task automatic drive(input logic [3:0] req, input logic sack, input logic rst);
        @(negedge CLK);
        M_req = req; S_ack = sack; RST = rst;
        #1;
        e_sreq = 1'b0; e_mack = 4'b0000; e_terr = 1'b0; m_exit = 1'b0;
        e_busy = (m_owner >= 0);
        if (m_owner >= 0 && !m_done) begin
            if (!req[m_owner]) m_exit = 1'b1;
            else if (sack) begin e_mack = 4'(1 << m_owner); m_exit = 1'b1; end
            else if (TMO_EN && m_cnt == TMO - 1) begin e_terr = 1'b1; m_exit = 1'b1; end
            else e_sreq = 1'b1;
        end
        exp_v = {e_sreq, e_mack, 2'(m_last), e_busy, e_terr, 2'(m_err)};
        obs_v = {S_req, M_ack, Select, Busy, Timeout_err, Err_id};
    endtask

    // Clock edge: advance the reference model
    task automatic tick();
        @(posedge CLK);
        if (RST) begin
            m_owner = -1; m_done = 1'b0; m_prio = 0; m_last = 0; m_err = 0; m_cnt = 0;
        end else if (m_owner >= 0 && m_done) begin
            m_prio = (m_owner + 1) % N; m_owner = -1; m_done = 1'b0;
        end else if (m_owner >= 0) begin
            if (m_exit) begin
                m_done = 1'b1;
                if (e_terr) m_err = m_owner;
            end else m_cnt++;
        end else begin
            for (int i = 0; i < N; i++)
                if (m_owner < 0 && M_req[(m_prio + i) % N]) begin
                    m_owner = (m_prio + i) % N; m_last = m_owner; m_cnt = 0;
                end
        end
    endtask

    task automatic test_reset();
        drive(4'b0000, 1'b0, 1'b1); tick();
        drive(4'b0000, 1'b0, 1'b0);
        checks++;
        if ({S_req, M_ack, Select, Busy, Timeout_err, Err_id} !== 11'd0) begin
            errors++; $display("FAIL reset_state: got %b want %b", obs_v, 11'd0);
        end
        tick();
    endtask

    task automatic test_single();
        drive(4'b0100, 1'b0, 1'b0); tick();
        drive(4'b0100, 1'b0, 1'b0);
        checks++;
        if (S_req !== 1'b1 || Select !== 2'd2 || M_ack !== 4'b0000) begin
            errors++; $display("FAIL single_grant1: got S_req=%b Select=%0d M_ack=%b want 1 2 0000", S_req, Select, M_ack);
        end
        tick();
        drive(4'b0100, 1'b1, 1'b0);
        checks++;
        if (S_req !== 1'b0 || M_ack !== 4'b0100) begin
            errors++; $display("FAIL single_ack: got S_req=%b M_ack=%b want 0 0100", S_req, M_ack);
        end
        tick();
        drive(4'b0000, 1'b0, 1'b0);
        checks++;
        if (Busy !== 1'b1 || S_req !== 1'b0) begin
            errors++; $display("FAIL single_done: got Busy=%b S_req=%b want 1 0", Busy, S_req);
        end
        tick();
        drive(4'b1111, 1'b0, 1'b0);
        checks++;
        if (Busy !== 1'b0) begin
            errors++; $display("FAIL single_idle: got Busy=%b want 0", Busy);
        end
        tick();
        drive(4'b1111, 1'b0, 1'b0);
        checks++;
        if (Select !== 2'd3 || S_req !== 1'b1) begin
            errors++; $display("FAIL single_ptr: got Select=%0d S_req=%b want 3 1", Select, S_req);
        end
        tick();
        drive(4'b0000, 1'b0, 1'b0); tick();
        drive(4'b0000, 1'b0, 1'b0); tick();
        drive(4'b0000, 1'b0, 1'b0); tick();
    endtask

    task automatic test_round_robin();
        int order[$];
        int when[$];
        drive(4'b0000, 1'b0, 1'b1); tick();
        for (int c = 0; c < 15; c++) begin
            drive(4'b1111, 1'b1, 1'b0);
            checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL rr_cycle%0d: got %b want %b", c, obs_v, exp_v);
            end
            for (int b = 0; b < N; b++)
                if (M_ack[b]) begin order.push_back(b); when.push_back(c); end
            tick();
        end
        checks++;
        if (order.size() != 5) begin
            errors++; $display("FAIL rr_count: got %0d acks want 5", order.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (order[k] != k % N || (k > 0 && when[k] - when[k-1] != 3)) begin
                    errors++; $display("FAIL rr_order%0d: got master %0d gap %0d want %0d gap 3",
                                       k, order[k], k > 0 ? when[k] - when[k-1] : 3, k % N);
                end
            end
        end
        drive(4'b0000, 1'b0, 1'b1); tick();
    endtask

    task automatic test_abort_with_ack();
        drive(4'b0010, 1'b0, 1'b0); tick();
        drive(4'b0010, 1'b0, 1'b0); tick();
        drive(4'b1101, 1'b1, 1'b0);
        checks++;
        if (M_ack !== 4'b0000 || S_req !== 1'b0 || obs_v !== exp_v) begin
            errors++; $display("FAIL abort_beats_ack: got M_ack=%b S_req=%b want 0000 0", M_ack, S_req);
        end
        tick();
        drive(4'b1101, 1'b0, 1'b0); tick();
        drive(4'b1101, 1'b0, 1'b0); tick();
        drive(4'b1101, 1'b0, 1'b0);
        checks++;
        if (Select !== 2'd2 || S_req !== 1'b1) begin
            errors++; $display("FAIL abort_next: got Select=%0d S_req=%b want 2 1", Select, S_req);
        end
        tick();
        for (int c = 0; c < 3; c++) begin drive(4'b0000, 1'b0, 1'b0); tick(); end
    endtask

    task automatic test_reset_mid_grant();
        drive(4'b0000, 1'b0, 1'b1); tick();
        drive(4'b0100, 1'b0, 1'b0); tick();
        drive(4'b0100, 1'b0, 1'b0); tick();
        drive(4'b0100, 1'b0, 1'b1);
        checks++;
        if (S_req !== 1'b1) begin
            errors++; $display("FAIL rstmid_before: got S_req=%b want 1", S_req);
        end
        tick();
        drive(4'b0110, 1'b0, 1'b0);
        checks++;
        if (S_req !== 1'b0 || Select !== 2'd0 || Busy !== 1'b0 || M_ack !== 4'b0000) begin
            errors++; $display("FAIL rstmid_after: got S_req=%b Select=%0d Busy=%b want 0 0 0", S_req, Select, Busy);
        end
        tick();
        drive(4'b0110, 1'b0, 1'b0);
        checks++;
        if (Select !== 2'd1 || S_req !== 1'b1) begin
            errors++; $display("FAIL rstmid_regrant: got Select=%0d S_req=%b want 1 1", Select, S_req);
        end
        tick();
        for (int c = 0; c < 3; c++) begin drive(4'b0000, 1'b0, 1'b0); tick(); end
    endtask

    task automatic test_watchdog();
        drive(4'b0000, 1'b0, 1'b1); tick();
        drive(4'b1000, 1'b0, 1'b0); tick();
`ifdef FPU_ARB_TIMEOUT_EN
        for (int k = 1; k <= TMO; k++) begin
            drive(4'b1000, 1'b0, 1'b0);
            checks++;
            if (Timeout_err !== (k == TMO) || S_req !== (k != TMO) || M_ack !== 4'b0000) begin
                errors++; $display("FAIL wdog_cycle%0d: got Timeout_err=%b S_req=%b M_ack=%b", k, Timeout_err, S_req, M_ack);
            end
            tick();
        end
        drive(4'b1001, 1'b0, 1'b0);
        checks++;
        if (Err_id !== 2'd3 || Timeout_err !== 1'b0) begin
            errors++; $display("FAIL wdog_errid: got Err_id=%0d Timeout_err=%b want 3 0", Err_id, Timeout_err);
        end
        tick();
        drive(4'b1001, 1'b0, 1'b0); tick();
        drive(4'b1001, 1'b0, 1'b0);
        checks++;
        if (Select !== 2'd0 || S_req !== 1'b1) begin
            errors++; $display("FAIL wdog_next: got Select=%0d want 0", Select);
        end
        tick();
`else
        for (int k = 1; k <= 210; k++) begin
            drive(4'b1000, 1'b0, 1'b0);
            checks++;
            if (S_req !== 1'b1 || Timeout_err !== 1'b0 || Err_id !== 2'd0) begin
                errors++; $display("FAIL nowdog_cycle%0d: got S_req=%b Timeout_err=%b want 1 0", k, S_req, Timeout_err);
            end
            tick();
        end
`endif
        for (int c = 0; c < 3; c++) begin drive(4'b0000, 1'b0, 1'b0); tick(); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            drive(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 149) == 0));
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL random_cycle%0d: got {S_req,M_ack,Select,Busy,Terr,Err_id}=%b want %b", c, obs_v, exp_v);
            end
            tick();
        end
    endtask

    initial begin
        M_req = 4'b0000; S_ack = 1'b0; RST = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_abort_with_ack();
        test_reset_mid_grant();
        test_watchdog();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
